// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encodings and
// instruction field positions.
package hazard_pkg;
  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] BUBBLE  = 2'd1;
  localparam logic [1:0] MEMWAIT = 2'd2;

  localparam int RS1_MSB = 19;
  localparam int RS1_LSB = 15;
  localparam int RS2_MSB = 24;
  localparam int RS2_LSB = 20;

  localparam logic [4:0] X0_IDX = 5'd0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The master modport is the
// pipeline side that supplies hazard inputs; the slave is the controller.
interface hazard_ctrl_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] id_inst_i;
  logic            ex_memread_i;
  logic [4:0]      ex_rd_i;
  logic            branch_taken_i;
  logic            mem_stall_i;
  logic            pc_write_o;
  logic            ifid_enable_o;
  logic            ifid_flush_o;
  logic            idex_enable_o;
  logic            idex_flush_o;
  logic            back_enable_o;
  logic [1:0]      state_o;
  logic [XLEN-1:0] stall_cnt_o;
  logic [XLEN-1:0] flush_cnt_o;

  modport master (
    output id_inst_i, ex_memread_i, ex_rd_i, branch_taken_i, mem_stall_i,
    input  pc_write_o, ifid_enable_o, ifid_flush_o, idex_enable_o,
           idex_flush_o, back_enable_o, state_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  id_inst_i, ex_memread_i, ex_rd_i, branch_taken_i, mem_stall_i,
    output pc_write_o, ifid_enable_o, ifid_flush_o, idex_enable_o,
           idex_flush_o, back_enable_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/sat_counter.sv
// XLEN-wide up-counter that sticks at all-ones; async active-low reset.
module sat_counter #(parameter int XLEN = 32) (
  input  logic            clock_i,
  input  logic            rst_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] count_o
);
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i)                      count_o <= '0;
    else if (inc_i && count_o != '1) count_o <= count_o + ONE;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: mem stall > load-use > branch.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(parameter int XLEN = 32) (
  input logic          clock_i,
  input logic          rst_i,
  hazard_ctrl_if.slave hif
);
  logic [1:0] state, state_nxt;
  logic       pend, pend_nxt;
  logic [4:0] rs1, rs2;
  logic       lu, br;
  logic       pc_write, ifid_en, ifid_flush, idex_en, idex_flush, back_en;

  assign rs1 = hif.id_inst_i[RS1_MSB:RS1_LSB];
  assign rs2 = hif.id_inst_i[RS2_MSB:RS2_LSB];

  wire unused_inst = ^{hif.id_inst_i[XLEN-1:RS2_MSB+1], hif.id_inst_i[RS1_LSB-1:0]};

  // The bubble cycle already covers the hazard, so lu is masked there.
  assign lu = (state != BUBBLE) && hif.ex_memread_i && (hif.ex_rd_i != X0_IDX) &&
              ((hif.ex_rd_i == rs1) || (hif.ex_rd_i == rs2));
  assign br = hif.branch_taken_i | pend;

  always_comb begin
    pc_write   = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    back_en    = 1'b0;
    state_nxt  = state;
    pend_nxt   = pend;
    if (!rst_i) begin
      state_nxt = RUN;
      pend_nxt  = 1'b0;
    end else if (hif.mem_stall_i) begin
      state_nxt = MEMWAIT;
      pend_nxt  = pend | hif.branch_taken_i;
    end else if (lu) begin
      // Branch is not lost: it is re-presented next cycle, or still held in pend.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      back_en    = 1'b1;
      state_nxt  = BUBBLE;
    end else begin
      pc_write   = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      back_en    = 1'b1;
      ifid_flush = br;
      pend_nxt   = 1'b0;
      state_nxt  = RUN;
    end
  end

  always_ff @(posedge clock_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= RUN;
      pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      pend  <= pend_nxt;
    end
  end

  assign hif.pc_write_o    = pc_write;
  assign hif.ifid_enable_o = ifid_en;
  assign hif.ifid_flush_o  = ifid_flush;
  assign hif.idex_enable_o = idex_en;
  assign hif.idex_flush_o  = idex_flush;
  assign hif.back_enable_o = back_en;
  assign hif.state_o       = rst_i ? state : RUN;

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.XLEN(XLEN)) u_stall_cnt (
    .clock_i (clock_i),
    .rst_i   (rst_i),
    .inc_i   (rst_i && !pc_write),
    .count_o (hif.stall_cnt_o)
  );
  sat_counter #(.XLEN(XLEN)) u_flush_cnt (
    .clock_i (clock_i),
    .rst_i   (rst_i),
    .inc_i   (ifid_flush),
    .count_o (hif.flush_cnt_o)
  );
`else
  assign hif.stall_cnt_o = '0;
  assign hif.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model.
module tb_hazard_ctrl;
  localparam int XLEN = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.XLEN(XLEN)) hif();
  hazard_ctrl #(.XLEN(XLEN)) dut (.clock_i(clk), .rst_i(rst), .hif(hif));

  int total = 0;
  int bad   = 0;

  // Model: "last cycle was a bubble", "waiting on memory", "a flush is owed".
  bit m_bubble, m_wait, m_owed;
  bit n_bubble, n_wait, n_owed;
  logic [XLEN-1:0] m_scnt, m_fcnt;
  bit e_pc, e_ife, e_iff, e_ide, e_idf, e_be;
  logic [1:0] e_st;

  task automatic model_reset();
    m_bubble = 0; m_wait = 0; m_owed = 0;
    m_scnt = '0; m_fcnt = '0;
  endtask

  task automatic model_eval();
    logic [4:0] r1, r2;
    bit hz;
    r1 = hif.id_inst_i[19:15];
    r2 = hif.id_inst_i[24:20];
    {e_pc, e_ife, e_iff, e_ide, e_idf, e_be} = '0;
    n_bubble = m_bubble; n_wait = m_wait; n_owed = m_owed;
    e_st = !rst ? 2'd0 : m_wait ? 2'd2 : m_bubble ? 2'd1 : 2'd0;
    hz = !m_bubble && hif.ex_memread_i && hif.ex_rd_i != 0 &&
         (hif.ex_rd_i == r1 || hif.ex_rd_i == r2);
    if (!rst) begin
      n_bubble = 0; n_wait = 0; n_owed = 0;
    end else if (hif.mem_stall_i) begin
      n_wait = 1; n_bubble = 0; n_owed = m_owed | hif.branch_taken_i;
    end else if (hz) begin
      e_ide = 1; e_idf = 1; e_be = 1;
      n_bubble = 1; n_wait = 0;
    end else begin
      e_pc = 1; e_ife = 1; e_ide = 1; e_be = 1;
      e_iff = hif.branch_taken_i | m_owed;
      n_owed = 0; n_bubble = 0; n_wait = 0;
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input bit mr,
                       input logic [4:0] rd, input bit br, input bit ms);
    logic [XLEN-1:0] inst;
    inst = $urandom;
    inst[19:15] = rs1;
    inst[24:20] = rs2;
    hif.id_inst_i      = inst;
    hif.ex_memread_i   = mr;
    hif.ex_rd_i        = rd;
    hif.branch_taken_i = br;
    hif.mem_stall_i    = ms;
    model_eval();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      if (!e_pc && m_scnt != '1) m_scnt = m_scnt + 1;
      if (e_iff && m_fcnt != '1) m_fcnt = m_fcnt + 1;
      m_bubble = n_bubble; m_wait = n_wait; m_owed = n_owed;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    total++; if (hif.pc_write_o !== 1'b0) begin bad++; $display("FAIL rst_pc got=%b want=0", hif.pc_write_o); end
    total++; if (hif.ifid_enable_o !== 1'b0 || hif.idex_enable_o !== 1'b0 || hif.back_enable_o !== 1'b0) begin
      bad++; $display("FAIL rst_en got=%b%b%b want=000", hif.ifid_enable_o, hif.idex_enable_o, hif.back_enable_o); end
    total++; if (hif.ifid_flush_o !== 1'b0 || hif.idex_flush_o !== 1'b0) begin
      bad++; $display("FAIL rst_flush got=%b%b want=00", hif.ifid_flush_o, hif.idex_flush_o); end
    total++; if (hif.state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", hif.state_o); end
    total++; if (hif.stall_cnt_o !== '0 || hif.flush_cnt_o !== '0) begin
      bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", hif.stall_cnt_o, hif.flush_cnt_o); end
    tick();
    @(negedge clk);
    rst = 1;
    model_eval();
    #1;
    total++; if (hif.ifid_flush_o !== 1'b1) begin bad++; $display("FAIL rel_flush got=%b want=1", hif.ifid_flush_o); end
    total++; if (hif.state_o !== 2'd0) begin bad++; $display("FAIL rel_state got=%0d want=0", hif.state_o); end
    tick();
  endtask

  task automatic test_load_use();
    drive(5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    total++; if ({hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.idex_flush_o, hif.back_enable_o} !== 5'b00111) begin
      bad++; $display("FAIL lu_strobes got=%b want=00111", {hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.idex_flush_o, hif.back_enable_o}); end
    tick();
    drive(5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
    total++; if (hif.state_o !== 2'd1) begin bad++; $display("FAIL lu_bubble_state got=%0d want=1", hif.state_o); end
    total++; if (hif.pc_write_o !== 1'b1 || hif.idex_flush_o !== 1'b0) begin
      bad++; $display("FAIL lu_one_cycle got=%b%b want=10", hif.pc_write_o, hif.idex_flush_o); end
    tick();
    drive(5'd3, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0);
    total++; if (hif.state_o !== 2'd0) begin bad++; $display("FAIL lu_back_run got=%0d want=0", hif.state_o); end
    tick();
    drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    total++; if (hif.pc_write_o !== 1'b1 || hif.idex_flush_o !== 1'b0) begin
      bad++; $display("FAIL lu_x0 got=%b%b want=10", hif.pc_write_o, hif.idex_flush_o); end
    tick();
  endtask

  task automatic test_branch();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b1) begin bad++; $display("FAIL br_flush got=%b want=1", hif.ifid_flush_o); end
    total++; if ({hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.back_enable_o} !== 4'b1111) begin
      bad++; $display("FAIL br_en got=%b want=1111", {hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.back_enable_o}); end
    tick();
    total++; if (hif.flush_cnt_o !== (PERF ? m_fcnt : '0)) begin
      bad++; $display("FAIL br_fcnt got=%0d want=%0d", hif.flush_cnt_o, PERF ? m_fcnt : '0); end
  endtask

  task automatic test_mem_stall();
    logic [XLEN-1:0] base;
    base = hif.stall_cnt_o;
    for (int i = 0; i < 3; i++) begin
      drive(5'd1, 5'd2, 1'b0, 5'd0, i == 1, 1'b1);
      total++; if ({hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.back_enable_o, hif.ifid_flush_o} !== 5'b0) begin
        bad++; $display("FAIL ms_frozen cyc=%0d got=%b want=00000", i, {hif.pc_write_o, hif.ifid_enable_o, hif.idex_enable_o, hif.back_enable_o, hif.ifid_flush_o}); end
      tick();
    end
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (hif.state_o !== 2'd2) begin bad++; $display("FAIL ms_state got=%0d want=2", hif.state_o); end
    total++; if (hif.ifid_flush_o !== 1'b1) begin bad++; $display("FAIL ms_pend_flush got=%b want=1", hif.ifid_flush_o); end
    total++; if (hif.stall_cnt_o - base !== (PERF ? 32'd3 : 32'd0)) begin
      bad++; $display("FAIL ms_scnt got=%0d want=%0d", hif.stall_cnt_o - base, PERF ? 3 : 0); end
    tick();
  endtask

  task automatic test_lu_branch();
    drive(5'd7, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b0 || hif.idex_flush_o !== 1'b1) begin
      bad++; $display("FAIL lubr_bubble got=%b%b want=01", hif.ifid_flush_o, hif.idex_flush_o); end
    tick();
    drive(5'd7, 5'd1, 1'b0, 5'd0, 1'b1, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b1) begin bad++; $display("FAIL lubr_flush got=%b want=1", hif.ifid_flush_o); end
    tick();
  endtask

  task automatic test_pend_through_bubble();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(5'd4, 5'd2, 1'b1, 5'd4, 1'b0, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b0 || hif.idex_flush_o !== 1'b1) begin
      bad++; $display("FAIL pend_lu got=%b%b want=01", hif.ifid_flush_o, hif.idex_flush_o); end
    tick();
    drive(5'd4, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b1) begin bad++; $display("FAIL pend_late_flush got=%b want=1", hif.ifid_flush_o); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1);
    rst = 0;
    model_reset();
    model_eval();
    #1;
    total++; if (hif.state_o !== 2'd0 || hif.stall_cnt_o !== '0) begin
      bad++; $display("FAIL midrst_async got=%0d/%0d want=0/0", hif.state_o, hif.stall_cnt_o); end
    tick();
    @(negedge clk);
    rst = 1;
    tick();
    drive(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    total++; if (hif.ifid_flush_o !== 1'b0) begin bad++; $display("FAIL midrst_noflush got=%b want=0", hif.ifid_flush_o); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3), $urandom_range(3), $urandom_range(1), $urandom_range(3),
            ($urandom_range(3) == 0), ($urandom_range(3) == 0));
      total++; if ({hif.pc_write_o, hif.ifid_enable_o, hif.ifid_flush_o, hif.idex_enable_o, hif.idex_flush_o, hif.back_enable_o}
                   !== {e_pc, e_ife, e_iff, e_ide, e_idf, e_be}) begin
        bad++; $display("FAIL rnd_strobes cyc=%0d got=%b want=%b", i,
          {hif.pc_write_o, hif.ifid_enable_o, hif.ifid_flush_o, hif.idex_enable_o, hif.idex_flush_o, hif.back_enable_o},
          {e_pc, e_ife, e_iff, e_ide, e_idf, e_be}); end
      total++; if (hif.state_o !== e_st) begin bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", i, hif.state_o, e_st); end
      total++; if (hif.stall_cnt_o !== (PERF ? m_scnt : '0) || hif.flush_cnt_o !== (PERF ? m_fcnt : '0)) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", i, hif.stall_cnt_o, hif.flush_cnt_o,
          PERF ? m_scnt : '0, PERF ? m_fcnt : '0); end
      tick();
    end
  endtask

  initial begin
    hif.id_inst_i = '0; hif.ex_memread_i = 0; hif.ex_rd_i = '0;
    hif.branch_taken_i = 0; hif.mem_stall_i = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_lu_branch();
    test_pend_through_bubble();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
